// File: rtl/imm_pkg.sv
// Shared opcode, immediate-format and handshake-state definitions for the
// immediate generator.
package imm_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate decoder: instruction word to
// sign-extended immediate, format code and illegal-opcode flag.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]      i_instr,
  output logic [XLEN-1:0]  o_imm,
  output logic [2:0]       o_fmt,
  output logic             o_illegal
);

  logic signed [31:0]      w_imm32;
  logic signed [XLEN-1:0]  w_imm_sx;

  always_comb begin
    w_imm32   = '0;
    o_fmt     = FMT_NONE;
    o_illegal = 1'b0;
    case (i_instr[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: begin
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
        o_fmt   = FMT_I;
      end
      OPC_STORE: begin
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        o_fmt   = FMT_S;
      end
      OPC_BRANCH: begin
        w_imm32 = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
        o_fmt   = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        w_imm32 = {i_instr[31:12], 12'b0};
        o_fmt   = FMT_U;
      end
      OPC_JAL: begin
        w_imm32 = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
        o_fmt   = FMT_J;
      end
      OPC_OP, OPC_FENCE: begin
        w_imm32 = '0;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

  // Signed-to-signed assignment widens by replicating bit 31 for XLEN=64.
  assign w_imm_sx = w_imm32;
  assign o_imm    = w_imm_sx;

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake, optional
// 2-entry skid buffer and a saturating illegal-opcode counter.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   imm,
  output logic [2:0]        fmt,
  output logic              illegal,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  illegal_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  logic [XLEN-1:0]  w_dec_imm;
  logic [2:0]       w_dec_fmt;
  logic             w_dec_illegal;
  entry_t           w_dec;
  entry_t           r_ent0;
  entry_t           r_ent1;
  skid_state_t      r_state;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_pop;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .i_instr   (instr),
    .o_imm     (w_dec_imm),
    .o_fmt     (w_dec_fmt),
    .o_illegal (w_dec_illegal)
  );

  assign w_dec     = {w_dec_imm, w_dec_fmt, w_dec_illegal};
  assign out_valid = (r_state != ST_EMPTY);
  assign in_ready  = SKID_EN ? r_in_ready : (!out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Entry-count FSM; r_ent0 is always the oldest entry. Without the skid
  // buffer in_ready forbids accept-without-pop in ST_ONE, so ST_TWO is unreachable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state <= ST_ONE;
            r_ent0  <= w_dec;
          end
        end
        ST_ONE: begin
          if (w_accept && !w_pop) begin
            r_state    <= ST_TWO;
            r_ent1     <= w_dec;
            r_in_ready <= 1'b0;
          end else if (w_accept) begin
            r_ent0 <= w_dec;
          end else if (w_pop) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            r_state    <= ST_ONE;
            r_ent0     <= r_ent1;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_EMPTY;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Payload reads zero whenever nothing is held, so stale data never leaks.
  assign imm     = out_valid ? r_ent0.imm : '0;
  assign fmt     = out_valid ? r_ent0.fmt : FMT_NONE;
  assign illegal = out_valid ? r_ent0.illegal : 1'b0;

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      r_cnt <= '0;
    end else if (w_accept && w_dec_illegal && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit skid-buffered instance and a 64-bit
// single-register instance with a 2-bit counter share one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_cnt = 1'b0;
  logic [31:0] instr = '0;

  logic        rdy_a, vld_a, ill_a;
  logic [31:0] imm_a;
  logic [2:0]  fmt_a;
  logic [15:0] cnt_a;
  logic        rdy_b, vld_b, ill_b;
  logic [63:0] imm_b;
  logic [2:0]  fmt_b;
  logic [1:0]  cnt_b;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SKID_EN(1'b1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .instr(instr),
    .out_valid(vld_a), .out_ready(out_ready), .imm(imm_a), .fmt(fmt_a),
    .illegal(ill_a), .clr_cnt(clr_cnt), .illegal_cnt(cnt_a)
  );

  imm_gen_pipe #(.XLEN(64), .SKID_EN(1'b0), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .instr(instr),
    .out_valid(vld_b), .out_ready(out_ready), .imm(imm_b), .fmt(fmt_b),
    .illegal(ill_b), .clr_cnt(clr_cnt), .illegal_cnt(cnt_b)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  exp_t        qa[$];
  exp_t        qb[$];
  int unsigned cnta = 0;
  int unsigned cntb = 0;
  bit          rdya = 1'b1;
  int          n_vec = 0;
  int          n_fail = 0;
  vec_t        tbl[11];
  logic [6:0]  ops[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Immediate value computed arithmetically from the bit-field weights.
  function automatic exp_t ref_dec(input logic [31:0] w);
    exp_t   e;
    longint v;
    v     = 0;
    e.fmt = 3'd0;
    e.ill = 1'b0;
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: begin
        v = longint'(w[31:20]) - (w[31] ? 64'sd4096 : 64'sd0);
        e.fmt = 3'd1;
      end
      7'h23: begin
        v = longint'(w[31:25]) * 32 + longint'(w[11:7]) - (w[31] ? 64'sd4096 : 64'sd0);
        e.fmt = 3'd2;
      end
      7'h63: begin
        v = longint'(w[11:8]) * 2 + longint'(w[30:25]) * 32 + longint'(w[7]) * 2048
            - (w[31] ? 64'sd4096 : 64'sd0);
        e.fmt = 3'd3;
      end
      7'h37, 7'h17: begin
        v = longint'(w[31:12]) * 4096 - (w[31] ? 64'sh1_0000_0000 : 64'sd0);
        e.fmt = 3'd4;
      end
      7'h6F: begin
        v = longint'(w[30:21]) * 2 + longint'(w[20]) * 2048 + longint'(w[19:12]) * 4096
            - (w[31] ? 64'sd1048576 : 64'sd0);
        e.fmt = 3'd5;
      end
      7'h33, 7'h0F: v = 0;
      default: e.ill = 1'b1;
    endcase
    e.imm = v;
    return e;
  endfunction

  task automatic check_duts();
    exp_t h;
    chk("a_valid", 64'(vld_a), 64'(qa.size() > 0));
    chk("a_ready", 64'(rdy_a), 64'(rdya));
    chk("a_cnt", 64'(cnt_a), 64'(cnta));
    if (qa.size() > 0) begin
      h = qa[0];
      chk("a_imm", 64'(imm_a), 64'(h.imm[31:0]));
      chk("a_fmt", 64'(fmt_a), 64'(h.fmt));
      chk("a_ill", 64'(ill_a), 64'(h.ill));
    end else begin
      chk("a_idle_payload", {29'd0, imm_a, fmt_a, ill_a}, 64'd0);
    end
    chk("b_valid", 64'(vld_b), 64'(qb.size() > 0));
    chk("b_ready", 64'(rdy_b), 64'((qb.size() == 0) || out_ready));
    chk("b_cnt", 64'(cnt_b), 64'(cntb));
    if (qb.size() > 0) begin
      h = qb[0];
      chk("b_imm", imm_b, h.imm);
      chk("b_fmt", 64'(fmt_b), 64'(h.fmt));
      chk("b_ill", 64'(ill_b), 64'(h.ill));
    end else begin
      chk("b_idle_imm", imm_b, 64'd0);
      chk("b_idle_fmt_ill", {60'd0, fmt_b, ill_b}, 64'd0);
    end
  endtask

  // One clock: check outputs against the model, then advance the model at the edge.
  task automatic step();
    bit   acc_a, acc_b, pop_a, pop_b;
    exp_t e;
    #1;
    check_duts();
    acc_a = in_valid && rdya;
    acc_b = in_valid && ((qb.size() == 0) || out_ready);
    pop_a = (qa.size() > 0) && out_ready;
    pop_b = (qb.size() > 0) && out_ready;
    e = ref_dec(instr);
    @(posedge clk);
    if (rst) begin
      qa.delete();
      qb.delete();
      cnta = 0;
      cntb = 0;
      rdya = 1'b1;
    end else begin
      if (pop_a) void'(qa.pop_front());
      if (pop_b) void'(qb.pop_front());
      if (acc_a) qa.push_back(e);
      if (acc_b) qb.push_back(e);
      if (clr_cnt) cnta = 0;
      else if (acc_a && e.ill && cnta < 65535) cnta++;
      if (clr_cnt) cntb = 0;
      else if (acc_b && e.ill && cntb < 3) cntb++;
      rdya = (qa.size() < 2);
    end
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{32'hFFC10113, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0};
    tbl[1]  = '{32'h00512423, 64'h0000000000000008, 3'd2, 1'b0};
    tbl[2]  = '{32'hFE000CE3, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0};
    tbl[3]  = '{32'h12345037, 64'h0000000012345000, 3'd4, 1'b0};
    tbl[4]  = '{32'h001000EF, 64'h0000000000000800, 3'd5, 1'b0};
    tbl[5]  = '{32'h0000007F, 64'h0000000000000000, 3'd0, 1'b1};
    tbl[6]  = '{32'h80000037, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
    tbl[7]  = '{32'h00000033, 64'h0000000000000000, 3'd0, 1'b0};
    tbl[8]  = '{32'h0000000F, 64'h0000000000000000, 3'd0, 1'b0};
    tbl[9]  = '{32'h00000073, 64'h0000000000000000, 3'd1, 1'b0};
    tbl[10] = '{32'h80000067, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b0};
    ops = '{7'h03, 7'h23, 7'h63, 7'h13, 7'h67, 7'h6F, 7'h37, 7'h17, 7'h73, 7'h33, 7'h0F, 7'h00};

    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state is covered by the first model check.
    step();

    // Fixed vectors: each result appears one cycle after acceptance.
    foreach (tbl[i]) begin
      in_valid  = 1'b1;
      instr     = tbl[i].instr;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d_a_imm", i), 64'(imm_a), 64'(tbl[i].imm[31:0]));
      chk($sformatf("vec%0d_a_fmt_ill", i), {60'd0, fmt_a, ill_a}, {60'd0, tbl[i].fmt, tbl[i].ill});
      chk($sformatf("vec%0d_b_imm", i), imm_b, tbl[i].imm);
      chk($sformatf("vec%0d_b_vld", i), 64'(vld_b), 64'd1);
    end
    chk("table_cnt_a", 64'(cnt_a), 64'd1);
    step();

    // Clear wins over a same-cycle illegal accept.
    in_valid = 1'b1;
    instr    = 32'h0000007F;
    clr_cnt  = 1'b1;
    step();
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    #1;
    chk("clr_prio_a", 64'(cnt_a), 64'd0);
    chk("clr_prio_b", 64'(cnt_b), 64'd0);
    step();

    // Back-pressure: skid instance takes two then stalls; drains in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr = 32'h00100093 + (32'(i) << 20);
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("skid_full_rdy", 64'(rdy_a), 64'd0);
    chk("skid_head_imm", 64'(imm_a), 64'd1);
    out_ready = 1'b1;
    step();
    #1;
    chk("skid_second_imm", 64'(imm_a), 64'd2);
    step();
    #1;
    chk("skid_drained", 64'(vld_a), 64'd0);

    // Reset with two entries held flushes both and clears the counter.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'h0000007F;
    step();
    step();
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst_flush_vld", 64'(vld_a), 64'd0);
    chk("rst_flush_cnt", 64'(cnt_a), 64'd0);
    chk("rst_ready", 64'(rdy_a), 64'd1);
    in_valid  = 1'b1;
    instr     = 32'h12345037;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    chk("post_rst_imm", 64'(imm_a), 64'h12345000);
    step();
    #1;
    chk("post_rst_only_one", 64'(vld_a), 64'd0);

    // Saturation of the 2-bit counter.
    in_valid = 1'b1;
    instr    = 32'h0000007F;
    repeat (5) step();
    in_valid = 1'b0;
    #1;
    chk("sat_cnt_b", 64'(cnt_b), 64'd3);
    chk("sat_cnt_a", 64'(cnt_a), 64'd5);
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] r;
      logic [6:0]  op;
      r         = $urandom();
      op        = ops[$urandom_range(0, 11)];
      if (op == 7'h00) op = r[6:0];
      instr     = {r[31:7], op};
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      clr_cnt   = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst      = 1'b0;
    clr_cnt  = 1'b0;
    in_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
